cla_serial_adder: RTL and testbench
===================================

// Module: cla_serial_adder
// PURPOSE
//  Multi-cycle wide adder that feeds the team's 4-bit carry_look_ahead slice (a,b,cin -> s,cout).
//  Accepts WIDTH-bit operands over a valid/ready handshake and drives one nibble per cycle into
//  a single CLA instance, LSB nibble first, registering the carry between nibbles.
//  Presents the assembled sum, carry-out and signed overflow on a valid/ready output.
// PARAMETERS
//  WIDTH    16   operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4  derived (localparam); number of CLA passes per operation
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in to LSB nibble
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer takes result
//  out_sum    out  WIDTH  in_a + in_b + in_cin, mod 2^WIDTH
//  out_cout   out  1      carry out of MSB
//  out_ovf    out  1      signed overflow = carry into MSB XOR out_cout
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, nibble index=0, carry reg=0, out_sum=0, out_cout=0,
//   out_ovf=0, out_valid=0; operand registers cleared. In-flight operation discarded, no output.
//  FSM: IDLE -> RUN on in_valid && in_ready (latch in_a, in_b; carry reg <= in_cin; idx <= 0).
//   RUN: each edge: out_sum[4*idx+:4] <= CLA.s, carry reg <= CLA.cout, idx <= idx+1;
//   CLA inputs = operand nibble idx and carry reg. On the edge processing idx==NIBBLES-1:
//   out_cout <= CLA.cout, out_ovf <= CLA.cout ^ (a[3]^b[3]^s[3]) of that nibble; -> DONE.
//  DONE: out_valid=1; out_sum/out_cout/out_ovf held stable until out_ready sampled high;
//   then -> IDLE (out_valid drops next cycle; result registers keep last value).
//  Latency: accept on edge T -> out_valid high after edge T+NIBBLES (NIBBLES cycles).
//  Throughput: no bypass; next accept earliest at edge T+NIBBLES+2 with out_ready held high.
//  in_valid/operand changes during RUN/DONE are ignored (in_ready=0); operands are not re-sampled.
//  out_ready while not in DONE has no effect. idx wraps to 0 on entry to IDLE/RUN only.
//  WIDTH==4: RUN lasts exactly one cycle. Nibble width of sum writes never exceeds WIDTH.
//  in_ready, out_valid, busy decoded from state registers only (no combinational in->out paths).
// TESTING (WIDTH=16 unless noted)
//  0x00FF + 0x0001, cin=0 -> out_sum=0x0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept
//  0xFFFF + 0x0000, cin=1 -> out_sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 passes)
//  0x7FFF + 0x0001, cin=0 -> out_sum=0x8000, cout=0, ovf=1; 0x8000+0x8000 -> 0x0000, cout=1, ovf=1
//  out_ready low 10 cycles in DONE -> out_valid and outputs stable; in_valid toggling ignored;
//   new operands accepted only 2 cycles after out_ready handshake
//  rst pulsed mid-RUN (after 2 nibbles) -> immediate IDLE, out_valid=0, out_sum=0; next op correct
//  WIDTH=4: 4'b1111 + 4'b0101, cin=1 -> sum=4'b0101, cout=1, ovf=0, out_valid 1 cycle after accept

Source files
------------

// File: rtl/cla_serial_adder_if.sv
// rtl/cla_serial_adder_if.sv - operand/result handshake bundle for cla_serial_adder
interface cla_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - multi-cycle wide adder driving one 4-bit CLA slice per nibble
module carry_look_ahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are expanded from generate/propagate terms, not rippled.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_serial_adder_if.slave     bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_cout;
    logic             accept;
    logic             last_nib;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_nib = (idx == LAST_IDX);

    // Select the operand nibble for the current pass with constant slices only.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    carry_look_ahead u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, one pass per cycle in RUN, hold in DONE until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last_nib) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then fold one CLA nibble into the sum per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
                carry <= bus.in_cin;
                idx   <= '0;
            end else if (state == RUN) begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx == IDX_W'(i)) begin
                        sum_q[4*i +: 4] <= nib_s;
                    end
                end
                carry <= nib_cout;
                if (last_nib) begin
                    cout_q <= nib_cout;
                    // Carry into the MSB is recovered from the top nibble's bit-3 sum.
                    ovf_q  <= nib_cout ^ (nib_a[3] ^ nib_b[3] ^ nib_s[3]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if ((state == DONE) && bus.out_ready) begin
                idx <= '0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - scoreboard bench for cla_serial_adder at WIDTH 16 and 4
module tb_cla_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_serial_adder_if #(.WIDTH(16)) bus16 ();
    cla_serial_adder_if #(.WIDTH(4))  bus4 ();

    cla_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb16[$];
    exp_t sb4[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model16(logic [15:0] a, logic [15:0] b, logic cin);
        exp_t        e;
        logic [16:0] f;
        f      = {1'b0, a} + {1'b0, b} + 17'(cin);
        e.sum  = f[15:0];
        e.cout = f[16];
        e.ovf  = (a[15] == b[15]) && (f[15] != a[15]);
        return e;
    endfunction

    function automatic exp_t model4(logic [3:0] a, logic [3:0] b, logic cin);
        exp_t       e;
        logic [4:0] f;
        f      = {1'b0, a} + {1'b0, b} + 5'(cin);
        e.sum  = {12'd0, f[3:0]};
        e.cout = f[4];
        e.ovf  = (a[3] == b[3]) && (f[3] != a[3]);
        return e;
    endfunction

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input int stall, input bit chk_lat, input bit toggle);
        exp_t e;
        int   lat;
        sb16.push_back(model16(a, b, cin));
        bus16.in_a     = a;
        bus16.in_b     = b;
        bus16.in_cin   = cin;
        bus16.in_valid = 1'b1;
        checks++;
        if (bus16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready16: in_ready=%b expected 1", bus16.in_ready);
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.in_a     = 16'($urandom);
        bus16.in_b     = 16'($urandom);
        bus16.in_cin   = 1'($urandom);
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) begin
            checks++;
            errors++;
            $display("FAIL timeout16: out_valid not seen within %0d cycles", lat);
            void'(sb16.pop_front());
            return;
        end
        if (chk_lat) begin
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL latency16: got %0d cycles expected 4", lat);
            end
        end
        e = sb16[0];
        for (int i = 0; i < stall; i++) begin
            if (toggle) begin
                bus16.in_valid = 1'($urandom_range(0, 1));
                bus16.in_a     = 16'($urandom);
                bus16.in_b     = 16'($urandom);
            end
            checks++;
            if (bus16.out_valid !== 1'b1 || bus16.out_sum !== e.sum || bus16.out_cout !== e.cout ||
                bus16.out_ovf !== e.ovf || bus16.in_ready !== 1'b0 || bus16.busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold16 cyc=%0d: valid=%b sum=%h cout=%b ovf=%b rdy=%b busy=%b expected 1 %h %b %b 0 1",
                         i, bus16.out_valid, bus16.out_sum, bus16.out_cout, bus16.out_ovf,
                         bus16.in_ready, bus16.busy, e.sum, e.cout, e.ovf);
            end
            @(negedge clk);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        e = sb16.pop_front();
        checks++;
        if (bus16.out_sum !== e.sum) begin
            errors++;
            $display("FAIL sum16 a=%h b=%h cin=%b: got %h expected %h", a, b, cin, bus16.out_sum, e.sum);
        end
        checks++;
        if (bus16.out_cout !== e.cout || bus16.out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL flags16 a=%h b=%h cin=%b: cout=%b ovf=%b expected %b %b",
                     a, b, cin, bus16.out_cout, bus16.out_ovf, e.cout, e.ovf);
        end
        @(negedge clk);
        bus16.out_ready = 1'b0;
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
            errors++;
            $display("FAIL release16: valid=%b rdy=%b busy=%b expected 0 1 0",
                     bus16.out_valid, bus16.in_ready, bus16.busy);
        end
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        exp_t e;
        int   lat;
        sb4.push_back(model4(a, b, cin));
        bus4.in_a     = a;
        bus4.in_b     = b;
        bus4.in_cin   = cin;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL latency4: got %0d cycles expected 1", lat);
        end
        bus4.out_ready = 1'b1;
        e = sb4.pop_front();
        checks++;
        if (bus4.out_sum !== e.sum[3:0] || bus4.out_cout !== e.cout || bus4.out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL result4 a=%h b=%h cin=%b: sum=%h cout=%b ovf=%b expected %h %b %b",
                     a, b, cin, bus4.out_sum, bus4.out_cout, bus4.out_ovf, e.sum[3:0], e.cout, e.ovf);
        end
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_cin = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.in_a  = '0; bus4.in_b  = '0; bus4.in_cin  = 1'b0; bus4.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.busy !== 1'b0 ||
            bus16.out_sum !== 16'h0 || bus16.out_cout !== 1'b0 || bus16.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset16: rdy=%b valid=%b busy=%b sum=%h cout=%b ovf=%b expected 1 0 0 0000 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.busy, bus16.out_sum, bus16.out_cout, bus16.out_ovf);
        end
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.out_sum !== 4'h0) begin
            errors++;
            $display("FAIL reset4: rdy=%b valid=%b sum=%h expected 1 0 0",
                     bus4.in_ready, bus4.out_valid, bus4.out_sum);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith;
        run_op16(16'h00FF, 16'h0001, 1'b0, 0, 1'b1, 1'b0);
        run_op16(16'hFFFF, 16'h0000, 1'b1, 0, 1'b1, 1'b0);
        run_op16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 1'b0);
        run_op16(16'h8000, 16'h8000, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_stall;
        run_op16(16'h1234, 16'hEDCB, 1'b1, 10, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        sb16.push_back(model16(16'hAAAA, 16'h5555, 1'b1));
        bus16.in_a = 16'hAAAA; bus16.in_b = 16'h5555; bus16.in_cin = 1'b1; bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        void'(sb16.pop_back());
        #1;
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.out_sum !== 16'h0 || bus16.busy !== 1'b0 ||
            bus16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run: valid=%b sum=%h busy=%b rdy=%b expected 0 0000 0 1",
                     bus16.out_valid, bus16.out_sum, bus16.busy, bus16.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op16(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            run_op16(16'($urandom), 16'($urandom), 1'($urandom), 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_width4;
        run_op4(4'b1111, 4'b0101, 1'b1);
        run_op4(4'b0111, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op4(4'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_stall;
        test_reset_mid_run;
        test_back_to_back;
        test_width4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
